modulo3_ctrl: RTL and testbench

FSM sequencer for the 13-bit signed shift-subtract modulo datapath (registers V, C, M1, nega, mod; control lines R1..R10).
Accepts a start request, drives the datapath control vector each cycle, and watches the datapath register values. It leaves mod = N mod M (result in 0..M-1) in the datapath mod register and signals completion with a one-cycle done pulse.
Sits between the polynomial-coefficient reduction sequencer (requester) and the datapath instance.

---
 rtl/modulo3_ctrl.sv | 142 ++++++++++++++
 tb/tb_modulo3_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo3_ctrl.sv
// Control sequencer for the shift-subtract modulo datapath: folds negative operands
// into range, then long-divides by M and leaves the remainder in the datapath mod register.
module modulo3_ctrl #(
    parameter int W     = 13,
    parameter int MW    = 4,
    parameter int ALIGN = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [MW-1:0] M,
    input  logic [W-1:0]  V,
    input  logic [W-1:0]  M1,
    input  logic [W-1:0]  nega,
    input  logic [MW-1:0] C,
    output logic          R1,
    output logic          R2,
    output logic          R3,
    output logic          R4,
    output logic          R5,
    output logic          R6,
    output logic          R7,
    output logic          R8,
    output logic          R9,
    output logic          R10,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        IDLE,
        NEG_FIX,
        XFER,
        REDUCE,
        FINAL,
        DONE
    } state_t;

    state_t state;

    logic          m_zero;
    logic          nega_neg;
    logic          v_ge_m1;
    logic [W-1:0]  c_ext;

    assign m_zero   = (M == '0);
    assign nega_neg = ($signed(nega) < 0);
    assign v_ge_m1  = (V >= M1);
    // M1 has been shifted back down to the bare modulus once it equals C
    assign c_ext    = {{ALIGN{1'b0}}, C};

    // busy/done/err are registered alongside the state so they decode cleanly
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (m_zero) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= NEG_FIX;
                        end
                    end
                end
                NEG_FIX: begin
                    if (!nega_neg) state <= XFER;
                end
                XFER: state <= REDUCE;
                REDUCE: begin
                    if (!v_ge_m1 && (M1 == c_ext)) state <= FINAL;
                end
                FINAL: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Control lines start from the hold vector; each state overrides only what it changes
    always_comb begin
        R1  = 1'b0;
        R2  = 1'b1;
        R3  = 1'b1;
        R4  = 1'b0;
        R5  = 1'b0;
        R6  = 1'b0;
        R7  = 1'b1;
        R8  = 1'b1;
        R9  = 1'b0;
        R10 = 1'b1;
        case (state)
            IDLE: begin
                if (start && !m_zero) begin
                    R3  = 1'b0;
                    R7  = 1'b0;
                    R6  = 1'b1;
                    R4  = 1'b1;
                    R10 = 1'b0;
                end
            end
            NEG_FIX: begin
                if (nega_neg) R9 = 1'b1;
            end
            XFER: begin
                R3 = 1'b0;
                R1 = 1'b1;
            end
            REDUCE: begin
                if (v_ge_m1) begin
                    R1 = 1'b1;
                end else if (M1 != c_ext) begin
                    R5 = 1'b1;
                    R6 = 1'b1;
                end
            end
            FINAL: R8 = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_modulo3_ctrl.sv
// Bench for modulo3_ctrl: a behavioural datapath answers the control lines, and results
// and latencies are compared with an arithmetic model of N mod M and the cycle budget.
module tb_modulo3_ctrl;

    localparam logic [9:0] HOLD_VEC = 10'b0110001101; // R1..R10

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [3:0]         m_bus = 4'd0;
    logic signed [12:0] n_bus = 13'sd0;
    logic [12:0]        dp_v = '0;
    logic [12:0]        dp_m1 = '0;
    logic [12:0]        dp_nega = '0;
    logic [3:0]         dp_c = '0;
    logic [12:0]        dp_mod = '0;
    logic R1, R2, R3, R4, R5, R6, R7, R8, R9, R10;
    logic busy, done, err;

    int vectors = 0;
    int miscompares = 0;

    modulo3_ctrl #(.W(13), .MW(4), .ALIGN(9)) dut (
        .clk(clk), .rst(rst), .start(start), .M(m_bus),
        .V(dp_v), .M1(dp_m1), .nega(dp_nega), .C(dp_c),
        .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5),
        .R6(R6), .R7(R7), .R8(R8), .R9(R9), .R10(R10),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: no reset, registers react only to their select lines
    always @(posedge clk) begin
        case ({R3, R1})
            2'b00: dp_v <= n_bus;
            2'b01: dp_v <= dp_nega;
            2'b11: dp_v <= dp_v - dp_m1;
            default: ;
        endcase
        if (!R7) dp_c <= m_bus;
        case ({R5, R6, R4})
            3'b011: dp_m1 <= {m_bus, 9'b0};
            3'b110: dp_m1 <= dp_m1 >> 1;
            default: ;
        endcase
        case ({R9, R10})
            2'b00: dp_nega <= n_bus;
            2'b11: dp_nega <= dp_nega + {9'b0, dp_c};
            default: ;
        endcase
        if (!R8) dp_mod <= dp_v;
    end

    function automatic int ref_mod(int n, int m);
        int r;
        r = n % m;
        if (r < 0) r += m;
        return r;
    endfunction

    // Cycles from accept edge to the done cycle: fold, transfer, long division, final, done
    function automatic int ref_latency(int n, int m);
        int fix, v0, q, subs;
        fix  = (n < 0) ? 1 + ((-n + m - 1) / m) : 1;
        v0   = (n < 0) ? ref_mod(n, m) : n;
        q    = v0 / m;
        subs = (q >> 9) + $countones(q & 511);
        return fix + 1 + (9 + subs + 1) + 1 + 1;
    endfunction

    task automatic run_op(input int n, input int m, output int lat, output int mod_out,
                          output logic err_out);
        n_bus = 13'(n);
        m_bus = 4'(m);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 6000) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        mod_out = int'(dp_mod);
        err_out = err;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        m_bus = 4'd5;
        n_bus = 13'sd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b want 0", err); end
        vectors++;
        if ({R1, R2, R3, R4, R5, R6, R7, R8, R9, R10} !== HOLD_VEC) begin
            miscompares++;
            $display("[TB] FAIL reset_hold got %b want %b",
                     {R1, R2, R3, R4, R5, R6, R7, R8, R9, R10}, HOLD_VEC);
        end
        @(negedge clk);
    endtask

    task automatic test_operands();
        int ns[6] = '{100, -7, 4095, -4096, 14, 10};
        int ms[6] = '{3, 3, 15, 1, 15, 4};
        int lat, md;
        logic e;
        for (int i = 0; i < 6; i++) begin
            run_op(ns[i], ms[i], lat, md, e);
            vectors++;
            if (md !== ref_mod(ns[i], ms[i])) begin
                miscompares++;
                $display("[TB] FAIL operand_mod N=%0d M=%0d got %0d want %0d", ns[i], ms[i], md, ref_mod(ns[i], ms[i]));
            end
            vectors++;
            if (lat !== ref_latency(ns[i], ms[i])) begin
                miscompares++;
                $display("[TB] FAIL operand_latency N=%0d M=%0d got %0d want %0d", ns[i], ms[i], lat, ref_latency(ns[i], ms[i]));
            end
            vectors++;
            if (e !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL operand_err N=%0d M=%0d got %b want 0", ns[i], ms[i], e);
            end
        end
    endtask

    task automatic test_zero_m();
        int lat, md, prev;
        logic e;
        prev = int'(dp_mod);
        run_op(50, 0, lat, md, e);
        vectors++;
        if (lat !== 1) begin miscompares++; $display("[TB] FAIL zero_m_latency got %0d want 1", lat); end
        vectors++;
        if (e !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_m_err got %b want 1", e); end
        vectors++;
        if (md !== prev) begin miscompares++; $display("[TB] FAIL zero_m_mod got %0d want %0d", md, prev); end
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_m_err_held got %b want 1", err); end
        run_op(20, 7, lat, md, e);
        vectors++;
        if (e !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_m_err_clear got %b want 0", e); end
        vectors++;
        if (md !== ref_mod(20, 7)) begin miscompares++; $display("[TB] FAIL zero_m_next_mod got %0d want %0d", md, ref_mod(20, 7)); end
    endtask

    task automatic test_back_to_back();
        int lat;
        n_bus = 13'sd100;
        m_bus = 4'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 6000) begin
            if (lat == 4) begin start = 1'b1; n_bus = 13'sd5; end
            else start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== ref_latency(100, 3)) begin miscompares++; $display("[TB] FAIL busy_start_latency got %0d want %0d", lat, ref_latency(100, 3)); end
        vectors++;
        if (int'(dp_mod) !== ref_mod(100, 3)) begin miscompares++; $display("[TB] FAIL busy_start_mod got %0d want %0d", dp_mod, ref_mod(100, 3)); end
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_start_ignored got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid();
        int prev, seen, lat, md;
        logic e;
        prev = int'(dp_mod);
        n_bus = 13'sd100;
        m_bus = 4'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_idle got busy=%b done=%b want 0 0", busy, done);
        end
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (done) seen++;
        end
        vectors++;
        if (seen !== 0) begin miscompares++; $display("[TB] FAIL reset_mid_no_done got %0d pulses want 0", seen); end
        vectors++;
        if (int'(dp_mod) !== prev) begin miscompares++; $display("[TB] FAIL reset_mid_mod_kept got %0d want %0d", dp_mod, prev); end
        run_op(10, 4, lat, md, e);
        vectors++;
        if (md !== 2) begin miscompares++; $display("[TB] FAIL reset_mid_restart got %0d want 2", md); end
    endtask

    task automatic test_random();
        int n, m, lat, md;
        logic e;
        for (int i = 0; i < 40; i++) begin
            m = int'($urandom_range(15, 1));
            n = int'($urandom_range(4607, 0)) - 512;
            run_op(n, m, lat, md, e);
            vectors++;
            if (md !== ref_mod(n, m)) begin
                miscompares++;
                $display("[TB] FAIL random_mod N=%0d M=%0d got %0d want %0d", n, m, md, ref_mod(n, m));
            end
            vectors++;
            if (lat !== ref_latency(n, m)) begin
                miscompares++;
                $display("[TB] FAIL random_latency N=%0d M=%0d got %0d want %0d", n, m, lat, ref_latency(n, m));
            end
            vectors++;
            if ({R1, R2, R3, R4, R5, R6, R7, R8, R9, R10} !== HOLD_VEC) begin
                miscompares++;
                $display("[TB] FAIL random_idle_hold got %b want %b",
                         {R1, R2, R3, R4, R5, R6, R7, R8, R9, R10}, HOLD_VEC);
            end
        end
    endtask

    initial begin
        test_reset();
        test_operands();
        test_zero_m();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
